// File: rtl/bank_isu_dispatch.sv
// bank_isu_dispatch
//   Downstream stage of the bank issue queue. The IQ head is popped when it is
//   valid, its MSHR-allow bit is set, a data-array credit is free, and the
//   one-entry output register can accept it. The output register drives the
//   bank data-array pipe with valid/ready. This block owns the credit counter.
//
//   Optional build macro: BANK_ISU_DISP_PERF_EN enables the stall counters.
//   When it is undefined, both stall outputs are tied to zero.
//
//   Ports
//     clk_i, rst_n_i           clock, asynchronous active-low reset
//     iq_valid_i / iq_pop_o    IQ head valid / head consumed this cycle
//     iq_mshr_allow_i          head entry allowed to issue
//     iq_*_i fields            head entry payload
//     da_valid_o / da_ready_i  data-array request handshake
//     da_*_o fields            registered payload
//     da_credit_ret_i          data array returns one credit
//     credit_cnt_o             credits currently available
//     err_credit_ovf_o         sticky: credit returned while already full
//     stall_credit_cnt_o       cycles the head was blocked by zero credits
//     stall_mshr_cnt_o         cycles the head was blocked by mshr_allow = 0
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_EMPTY | output register empty, da_valid_o = 0
//   S_FULL  | output register holds an entry, da_valid_o = 1

module bank_isu_dispatch #(
   parameter  int CREDITS  = 4,
   parameter  int PERF_W   = 16,
   localparam int CREDIT_W = $clog2(CREDITS + 1)
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                iq_valid_i,
   output logic                iq_pop_o,
   input  logic                iq_mshr_allow_i,
   input  logic [2:0]          iq_rob_id_i,
   input  logic [1:0]          iq_ch_id_i,
   input  logic [1:0]          iq_opcode_i,
   input  logic [6:0]          iq_set_way_offset_i,
   input  logic [7:0]          iq_wbuffer_id_i,
   input  logic [3:0]          iq_cl_state_i,
   output logic                da_valid_o,
   input  logic                da_ready_i,
   output logic [2:0]          da_rob_id_o,
   output logic [1:0]          da_ch_id_o,
   output logic [1:0]          da_opcode_o,
   output logic [6:0]          da_set_way_offset_o,
   output logic [7:0]          da_wbuffer_id_o,
   output logic [3:0]          da_cl_state_o,
   input  logic                da_credit_ret_i,
   output logic [CREDIT_W-1:0] credit_cnt_o,
   output logic                err_credit_ovf_o,
   output logic [PERF_W-1:0]   stall_credit_cnt_o,
   output logic [PERF_W-1:0]   stall_mshr_cnt_o
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                err_q;
   logic [25:0]         fields_q;
   logic                slot_free;
   logic                pop;
   logic                ovf;
   logic                ret_ok;
   logic                credit_zero;

   assign credit_zero = (credit_q == '0);
   assign slot_free   = (state_q == S_EMPTY) | da_ready_i;
   assign pop         = iq_valid_i & iq_mshr_allow_i & ~credit_zero & slot_free;

   // A return that arrives while the counter is already full and nothing is
   // being consumed in the same cycle has nowhere to go: drop it and flag it.
   assign ovf    = da_credit_ret_i & (credit_q == CREDIT_W'(CREDITS)) & ~pop;
   assign ret_ok = da_credit_ret_i & ~ovf;

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q - CREDIT_W'(pop) + CREDIT_W'(ret_ok);
      if (pop) begin
         state_d = S_FULL;
      end else if ((state_q == S_FULL) && da_ready_i) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_EMPTY;
         credit_q <= CREDIT_W'(CREDITS);
         err_q    <= 1'b0;
         fields_q <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         if (ovf) err_q <= 1'b1;
         if (pop) begin
            fields_q <= {iq_rob_id_i, iq_ch_id_i, iq_opcode_i, iq_set_way_offset_i,
                         iq_wbuffer_id_i, iq_cl_state_i};
         end
      end
   end

   assign iq_pop_o         = pop;
   assign da_valid_o       = (state_q == S_FULL);
   assign credit_cnt_o     = credit_q;
   assign err_credit_ovf_o = err_q;
   assign {da_rob_id_o, da_ch_id_o, da_opcode_o, da_set_way_offset_o,
           da_wbuffer_id_o, da_cl_state_o} = fields_q;

`ifdef BANK_ISU_DISP_PERF_EN
   logic [PERF_W-1:0] stall_credit_q;
   logic [PERF_W-1:0] stall_mshr_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_credit_q <= '0;
         stall_mshr_q   <= '0;
      end else begin
         if (iq_valid_i && iq_mshr_allow_i && credit_zero && (stall_credit_q != '1))
            stall_credit_q <= stall_credit_q + PERF_W'(1);
         if (iq_valid_i && !iq_mshr_allow_i && (stall_mshr_q != '1))
            stall_mshr_q <= stall_mshr_q + PERF_W'(1);
      end
   end

   assign stall_credit_cnt_o = stall_credit_q;
   assign stall_mshr_cnt_o   = stall_mshr_q;
`else
   assign stall_credit_cnt_o = '0;
   assign stall_mshr_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_bank_isu_dispatch.sv
module tb_bank_isu_dispatch;
   localparam int CREDITS  = 4;
   localparam int PERF_W   = 16;
   localparam int CREDIT_W = $clog2(CREDITS + 1);

   logic                clk_i = 1'b0;
   logic                rst_n_i;
   logic                iq_valid_i, iq_pop_o, iq_mshr_allow_i;
   logic [2:0]          iq_rob_id_i;
   logic [1:0]          iq_ch_id_i, iq_opcode_i;
   logic [6:0]          iq_set_way_offset_i;
   logic [7:0]          iq_wbuffer_id_i;
   logic [3:0]          iq_cl_state_i;
   logic                da_valid_o, da_ready_i;
   logic [2:0]          da_rob_id_o;
   logic [1:0]          da_ch_id_o, da_opcode_o;
   logic [6:0]          da_set_way_offset_o;
   logic [7:0]          da_wbuffer_id_o;
   logic [3:0]          da_cl_state_o;
   logic                da_credit_ret_i;
   logic [CREDIT_W-1:0] credit_cnt_o;
   logic                err_credit_ovf_o;
   logic [PERF_W-1:0]   stall_credit_cnt_o, stall_mshr_cnt_o;

   bank_isu_dispatch #(.CREDITS(CREDITS), .PERF_W(PERF_W)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .iq_valid_i(iq_valid_i), .iq_pop_o(iq_pop_o), .iq_mshr_allow_i(iq_mshr_allow_i),
      .iq_rob_id_i(iq_rob_id_i), .iq_ch_id_i(iq_ch_id_i), .iq_opcode_i(iq_opcode_i),
      .iq_set_way_offset_i(iq_set_way_offset_i), .iq_wbuffer_id_i(iq_wbuffer_id_i),
      .iq_cl_state_i(iq_cl_state_i),
      .da_valid_o(da_valid_o), .da_ready_i(da_ready_i),
      .da_rob_id_o(da_rob_id_o), .da_ch_id_o(da_ch_id_o), .da_opcode_o(da_opcode_o),
      .da_set_way_offset_o(da_set_way_offset_o), .da_wbuffer_id_o(da_wbuffer_id_o),
      .da_cl_state_o(da_cl_state_o),
      .da_credit_ret_i(da_credit_ret_i), .credit_cnt_o(credit_cnt_o),
      .err_credit_ovf_o(err_credit_ovf_o),
      .stall_credit_cnt_o(stall_credit_cnt_o), .stall_mshr_cnt_o(stall_mshr_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int pop_seen = 0;

   // reference model state
   logic [25:0] sb_q[$];
   bit          m_full;
   int          m_cnt;
   bit          m_err;
   int          m_stall_c, m_stall_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [25:0] head_fields();
      return {iq_rob_id_i, iq_ch_id_i, iq_opcode_i, iq_set_way_offset_i,
              iq_wbuffer_id_i, iq_cl_state_i};
   endfunction

   function automatic logic [25:0] da_fields();
      return {da_rob_id_o, da_ch_id_o, da_opcode_o, da_set_way_offset_o,
              da_wbuffer_id_o, da_cl_state_o};
   endfunction

   task automatic set_head(input logic [25:0] f);
      {iq_rob_id_i, iq_ch_id_i, iq_opcode_i, iq_set_way_offset_i,
       iq_wbuffer_id_i, iq_cl_state_i} = f;
   endtask

   task automatic model_reset();
      m_full = 0; m_cnt = CREDITS; m_err = 0; m_stall_c = 0; m_stall_m = 0;
      sb_q.delete();
   endtask

   // One clock cycle: inputs already driven; check at negedge, advance model, cross posedge.
   task automatic step();
      bit m_pop, hs, ovf;
      @(negedge clk_i);
      m_pop = iq_valid_i && iq_mshr_allow_i && (m_cnt != 0) && (!m_full || da_ready_i);
      hs    = m_full && da_ready_i;
      chk("pop", iq_pop_o, m_pop);
      chk("da_valid", da_valid_o, m_full);
      chk("credit_cnt", credit_cnt_o, m_cnt);
      chk("err_ovf", err_credit_ovf_o, m_err);
`ifdef BANK_ISU_DISP_PERF_EN
      chk("stall_credit", stall_credit_cnt_o, m_stall_c);
      chk("stall_mshr", stall_mshr_cnt_o, m_stall_m);
`else
      chk("stall_credit", stall_credit_cnt_o, 0);
      chk("stall_mshr", stall_mshr_cnt_o, 0);
`endif
      if (m_full) begin
         if (sb_q.size() == 0) chk("sb_empty", 1, 0);
         else chk("da_fields", da_fields(), sb_q[0]);
      end
      if (iq_pop_o) pop_seen++;
      if (hs && sb_q.size() != 0) void'(sb_q.pop_front());
      if (m_pop) sb_q.push_back(head_fields());
      if (iq_valid_i && iq_mshr_allow_i && m_cnt == 0) m_stall_c++;
      if (iq_valid_i && !iq_mshr_allow_i) m_stall_m++;
      ovf = da_credit_ret_i && (m_cnt == CREDITS) && !m_pop;
      if (ovf) m_err = 1;
      m_cnt = m_cnt - int'(m_pop) + int'(da_credit_ret_i && !ovf);
      m_full = m_pop ? 1'b1 : (hs ? 1'b0 : m_full);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      iq_valid_i = 0; iq_mshr_allow_i = 0; da_ready_i = 0; da_credit_ret_i = 0;
   endtask

   // drain output slot and return credits until the counter is full again (bounded)
   task automatic restore();
      iq_valid_i = 0; da_ready_i = 1; da_credit_ret_i = 1;
      for (int i = 0; i < 20 && (m_cnt != CREDITS || m_full); i++) begin
         if (m_cnt == CREDITS) da_credit_ret_i = 0;
         step();
      end
      da_credit_ret_i = 0;
      chk("restore", credit_cnt_o, CREDITS);
   endtask

   initial begin
      rst_n_i = 0;
      idle_inputs();
      set_head('0);
      model_reset();
      #12;
      chk("rst_da_valid", da_valid_o, 0);
      chk("rst_credit", credit_cnt_o, CREDITS);
      chk("rst_err", err_credit_ovf_o, 0);
      chk("rst_pop", iq_pop_o, 0);
      chk("rst_fields", da_fields(), 0);
      @(posedge clk_i); #1;
      rst_n_i = 1;

      // T1: single dispatch, 1-cycle latency
      iq_valid_i = 1; iq_mshr_allow_i = 1; da_ready_i = 1;
      set_head({3'd5, 2'd1, 2'd2, 7'h33, 8'hA5, 4'h9});
      step();
      iq_valid_i = 0;
      chk("t1_da_valid", da_valid_o, 1);
      chk("t1_rob", da_rob_id_o, 5);
      chk("t1_credit", credit_cnt_o, 3);
      step();

      // T2: credits exhaust after 4 pops, resume after a return
      restore();
      pop_seen = 0;
      iq_valid_i = 1; iq_mshr_allow_i = 1; da_ready_i = 1;
      for (int i = 0; i < 6; i++) begin
         set_head({3'(i), 2'(i), 2'(i + 1), 7'(i * 9), 8'(8'h10 + i), 4'(i)});
         step();
      end
      chk("t2_pops", pop_seen, 4);
      chk("t2_credit0", credit_cnt_o, 0);
      da_credit_ret_i = 1;
      step();
      da_credit_ret_i = 0;
      step();

      // T3: backpressure holds the slot, then back-to-back transfer
      restore();
      iq_valid_i = 1; iq_mshr_allow_i = 1; da_ready_i = 0;
      set_head({3'd3, 2'd3, 2'd1, 7'h55, 8'h3C, 4'hC});
      step();
      set_head({3'd6, 2'd2, 2'd3, 7'h2A, 8'hC3, 4'h3});
      for (int i = 0; i < 10; i++) step();
      chk("t3_held_rob", da_rob_id_o, 3);
      da_ready_i = 1;
      step();
      chk("t3_b2b_valid", da_valid_o, 1);
      chk("t3_b2b_rob", da_rob_id_o, 6);
      iq_valid_i = 0;
      step();

      // T4: simultaneous pop and return; overflow return
      restore();
      iq_valid_i = 1; iq_mshr_allow_i = 1; da_ready_i = 1;
      set_head({3'd1, 2'd0, 2'd0, 7'h01, 8'h01, 4'h1});
      step();
      step();
      chk("t4_credit2", credit_cnt_o, 2);
      da_credit_ret_i = 1;
      step();
      chk("t4_hold2", credit_cnt_o, 2);
      da_credit_ret_i = 0;
      restore();
      da_credit_ret_i = 1;
      step();
      da_credit_ret_i = 0;
      chk("t4_ovf_cnt", credit_cnt_o, 4);
      chk("t4_ovf_err", err_credit_ovf_o, 1);
      for (int i = 0; i < 3; i++) step();
      chk("t4_ovf_sticky", err_credit_ovf_o, 1);

      // T5: blocked head is not bypassed
      restore();
      iq_valid_i = 1; iq_mshr_allow_i = 0; da_ready_i = 1;
      set_head({3'd7, 2'd1, 2'd1, 7'h7F, 8'hEE, 4'h6});
      for (int i = 0; i < 7; i++) step();
`ifdef BANK_ISU_DISP_PERF_EN
      chk("t5_stall_mshr", stall_mshr_cnt_o, 7);
`endif
      iq_mshr_allow_i = 1;
      step();
      chk("t5_first_rob", da_rob_id_o, 7);
      set_head({3'd2, 2'd2, 2'd2, 7'h11, 8'h22, 4'h2});
      step();
      chk("t5_second_rob", da_rob_id_o, 2);
      iq_valid_i = 0;
      step();

      // T6: async reset while FULL with one credit left
      restore();
      iq_valid_i = 1; iq_mshr_allow_i = 1; da_ready_i = 1;
      set_head({3'd4, 2'd3, 2'd0, 7'h40, 8'h44, 4'hA});
      for (int i = 0; i < 3; i++) step();
      iq_valid_i = 0; da_ready_i = 0;
      step();
      chk("t6_pre_full", da_valid_o, 1);
      chk("t6_pre_credit", credit_cnt_o, 1);
      #2;
      rst_n_i = 0;
      #1;
      chk("t6_da_valid", da_valid_o, 0);
      chk("t6_credit", credit_cnt_o, CREDITS);
      chk("t6_pop", iq_pop_o, 0);
      chk("t6_err", err_credit_ovf_o, 0);
      model_reset();
      @(posedge clk_i); #1;
      rst_n_i = 1;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
